// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory: one request at a time.
// Define MAU_STORE_TRACE_EN to print a trace line for every store issued.
module mem_access_unit #(
  parameter int unsigned RD_LATENCY = 0,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  output logic        m_we,
  output logic        m_re,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        capture;
  logic        we_reg, sign_reg, exc_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg, wdata_reg, pc_reg, rdata_reg;
  logic        fault;
  logic        accept;
  logic [3:0]  be_full;
  logic [31:0] load_data;
  logic [7:0]  rd_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // pc is only consumed by the optional store trace
  logic unused_pc;
  assign unused_pc = ^pc_reg;

  assign accept = (state_reg == IDLE) && req_valid;
  assign fault  = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || (req_addr >= ADDR_LIMIT);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: if (req_valid) state_next = fault ? RESP : ISSUE;
      ISSUE: begin
        if (we_reg) begin
          state_next = RESP;
        end else if (RD_LATENCY == 0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next   = 4'(RD_LATENCY);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd1) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      sign_reg  <= 1'b0;
      exc_reg   <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      pc_reg    <= 32'd0;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= req_we;
        size_reg  <= req_size;
        sign_reg  <= req_sign;
        exc_reg   <= fault;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        pc_reg    <= req_pc;
      end
      if (capture) rdata_reg <= m_rdata;
    end
  end

  always_comb begin
    case (size_reg)
      2'b00:   be_full = 4'b0001 << addr_reg[1:0];
      2'b01:   be_full = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: be_full = 4'b1111;
    endcase
  end

  always_comb begin
    case (size_reg)
      2'b00:   m_wdata = {4{wdata_reg[7:0]}};
      2'b01:   m_wdata = {2{wdata_reg[15:0]}};
      default: m_wdata = wdata_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_lane[gi] = rdata_reg[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rd_lane[addr_reg[1:0]];
  assign half_sel = addr_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];

  always_comb begin
    case (size_reg)
      2'b00:   load_data = {{24{sign_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{sign_reg & half_sel[15]}}, half_sel};
      default: load_data = rdata_reg;
    endcase
  end

  // Address and enables stay stable through WAIT; strobes only in ISSUE.
  assign req_ready = (state_reg == IDLE);
  assign m_addr    = {addr_reg[31:2], 2'b00};
  assign m_be      = (state_reg == ISSUE || state_reg == WAIT) ? be_full : 4'b0000;
  assign m_we      = (state_reg == ISSUE) && we_reg;
  assign m_re      = (state_reg == ISSUE) && !we_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_exc   = (state_reg == RESP) && exc_reg;
  assign rsp_rdata = (state_reg == RESP && !we_reg && !exc_reg) ? load_data : 32'd0;

`ifdef MAU_STORE_TRACE_EN
  logic [31:0] trace_word;
  for (gi = 0; gi < 4; gi++) begin : g_trace_lane
    assign trace_word[8*gi +: 8] = m_be[gi] ? m_wdata[8*gi +: 8] : m_rdata[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset && m_we)
      $display("@%08h: *%08h <= %08h", pc_reg, m_addr, trace_word);
  end
`endif

endmodule
